// File: rtl/fetch_pkg.sv
// fetch_pkg: shared FSM encoding and default parameters for the instruction fetch stage.
package fetch_pkg;
    typedef enum logic [1:0] {FS_IDLE = 2'd0, FS_RUN = 2'd1, FS_HALT = 2'd2} fetch_state_t;
    localparam int INSTR_WIDTH_DEF = 20;
    localparam int PC_BITS_DEF = 5;
    localparam logic [INSTR_WIDTH_DEF-1:0] HALT_WORD_DEF = 20'hFFFFF;
endpackage

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: load/control requests and issued-instruction responses of the fetch stage.
interface instr_fetch_if import fetch_pkg::*; #(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_BITS = PC_BITS_DEF
) ();
    logic                   load_en;
    logic [PC_BITS-1:0]     load_addr;
    logic [INSTR_WIDTH-1:0] load_data;
    logic                   start;
    logic                   stall;
    logic                   jump_en;
    logic [PC_BITS-1:0]     jump_addr;
    logic [INSTR_WIDTH-1:0] instruction;
    logic                   instr_valid;
    logic [PC_BITS-1:0]     pc;
    logic                   busy;
    logic                   halted;

    modport master (
        output load_en, load_addr, load_data, start, stall, jump_en, jump_addr,
        input  instruction, instr_valid, pc, busy, halted
    );
    modport slave (
        input  load_en, load_addr, load_data, start, stall, jump_en, jump_addr,
        output instruction, instr_valid, pc, busy, halted
    );
endinterface

// File: rtl/prog_mem.sv
// prog_mem: program store with synchronous write and asynchronous read; contents are never reset.
module prog_mem #(
    parameter int INSTR_WIDTH = 20,
    parameter int PC_BITS = 5
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [PC_BITS-1:0]     waddr,
    input  logic [INSTR_WIDTH-1:0] wdata,
    input  logic [PC_BITS-1:0]     raddr,
    output logic [INSTR_WIDTH-1:0] rdata
);
    logic [INSTR_WIDTH-1:0] mem [2**PC_BITS];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC-driven fetch FSM issuing one registered instruction per cycle, with stall, jump and halt.
module instr_fetch import fetch_pkg::*; #(
    parameter int INSTR_WIDTH = INSTR_WIDTH_DEF,
    parameter int PC_BITS = PC_BITS_DEF,
    parameter logic [INSTR_WIDTH-1:0] HALT_WORD = HALT_WORD_DEF
) (
    input logic          clk,
    input logic          rst,
    instr_fetch_if.slave bus
);
    fetch_state_t state;
    logic [INSTR_WIDTH-1:0] word;

    prog_mem #(.INSTR_WIDTH(INSTR_WIDTH), .PC_BITS(PC_BITS)) u_mem (
        .clk   (clk),
        .we    (bus.load_en && state != FS_RUN),
        .waddr (bus.load_addr),
        .wdata (bus.load_data),
        .raddr (bus.pc),
        .rdata (word)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= FS_IDLE;
            bus.pc          <= '0;
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            bus.busy        <= 1'b0;
            bus.halted      <= 1'b0;
        end else if (state != FS_RUN) begin
            bus.instruction <= '0;
            bus.instr_valid <= 1'b0;
            if (bus.start) begin
                state      <= FS_RUN;
                bus.pc     <= '0;
                bus.busy   <= 1'b1;
                bus.halted <= 1'b0;
            end
        end else if (!bus.stall) begin
            // a jump costs one bubble: the target word is fetched on the following edge
            if (bus.jump_en) begin
                bus.pc          <= bus.jump_addr;
                bus.instruction <= '0;
                bus.instr_valid <= 1'b0;
            end else if (word == HALT_WORD) begin
                state           <= FS_HALT;
                bus.instruction <= '0;
                bus.instr_valid <= 1'b0;
                bus.busy        <= 1'b0;
                bus.halted      <= 1'b1;
            end else begin
                bus.instruction <= word;
                bus.instr_valid <= 1'b1;
                bus.pc          <= bus.pc + PC_BITS'(1);
            end
        end
    end
endmodule
